prog_clock_divider: RTL and testbench

Runtime-programmable, multi-channel clock divider generating NUM_CH independent divided clocks from the 100 MHz system clock, each with a programmable period and high time. It replaces fixed-ratio /2 and /10 dividers: any integer ratio ≥ 2, glitch-free ratio changes, gated start/stop, and a common phase-realignment strobe. It sits at the top of the clocking tree and feeds slow peripherals and LED/scan logic with divided clocks and per-channel tick pulses.

---
 rtl/clk_div_pkg.sv | 32 +++
 rtl/clk_div_channel.sv | 132 +++++++++++++
 rtl/prog_clock_divider.sv | 74 +++++++
 tb/tb_prog_clock_divider.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared state type, limits, reset constants and config clamping for the
// programmable clock divider.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEFAULT      = 16;
    localparam int unsigned DIV_MIN            = 2;
    localparam int unsigned DIV_RESET_DEFAULT  = 2;
    localparam int unsigned HIGH_RESET_DEFAULT = 1;
    localparam int unsigned CLAMP_W            = 32;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } ch_state_e;

    function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] div);
        return (div < CLAMP_W'(DIV_MIN)) ? CLAMP_W'(DIV_MIN) : div;
    endfunction

    // Expects an already clamped divide ratio so high always lands in 1..div-1.
    function automatic logic [CLAMP_W-1:0] clamp_high(input logic [CLAMP_W-1:0] high,
                                                      input logic [CLAMP_W-1:0] div_c);
        logic [CLAMP_W-1:0] h;
        h = (high == '0) ? CLAMP_W'(1) : high;
        if (h >= div_c) begin
            h = div_c - CLAMP_W'(1);
        end
        return h;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divided-clock channel: period counter, shadowed divide/high config with
// boundary-aligned update, and the run/stop control FSM.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W      = DIV_W_DEFAULT,
    parameter int unsigned DIV_RESET  = DIV_RESET_DEFAULT,
    parameter int unsigned HIGH_RESET = HIGH_RESET_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_we,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic [DIV_W-1:0] i_cfg_high,
    input  logic             i_en,
    input  logic             i_sync,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_running,
    output logic             o_pending
);

    ch_state_e        r_state, w_state_d;
    logic [DIV_W-1:0] r_cnt, w_cnt_d;
    logic [DIV_W-1:0] r_div, w_div_d;
    logic [DIV_W-1:0] r_high, w_high_d;
    logic [DIV_W-1:0] r_sdiv, w_sdiv_d;
    logic [DIV_W-1:0] r_shigh, w_shigh_d;
    logic             r_pend, w_pend_d;
    logic             r_clk, w_clk_d;
    logic             r_tick, w_tick_d;

    logic [DIV_W-1:0] w_cfg_div_c;
    logic [DIV_W-1:0] w_cfg_high_c;
    logic             w_boundary;
    logic             w_apply;

    assign w_cfg_div_c  = DIV_W'(clamp_div(CLAMP_W'(i_cfg_div)));
    assign w_cfg_high_c = DIV_W'(clamp_high(CLAMP_W'(i_cfg_high), CLAMP_W'(w_cfg_div_c)));
    assign w_boundary   = (r_cnt == (r_div - DIV_W'(1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_div   <= DIV_W'(DIV_RESET);
            r_high  <= DIV_W'(HIGH_RESET);
            r_sdiv  <= DIV_W'(DIV_RESET);
            r_shigh <= DIV_W'(HIGH_RESET);
            r_pend  <= 1'b0;
            r_clk   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_div   <= w_div_d;
            r_high  <= w_high_d;
            r_sdiv  <= w_sdiv_d;
            r_shigh <= w_shigh_d;
            r_pend  <= w_pend_d;
            r_clk   <= w_clk_d;
            r_tick  <= w_tick_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_div_d   = r_div;
        w_high_d  = r_high;
        w_sdiv_d  = r_sdiv;
        w_shigh_d = r_shigh;
        w_pend_d  = r_pend;
        w_clk_d   = 1'b0;
        w_tick_d  = 1'b0;
        w_apply   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_en) begin
                    w_state_d = StRun;
                    w_cnt_d   = '0;
                    w_apply   = r_pend;
                end
            end
            StRun, StStopping: begin
                w_clk_d  = (r_cnt < r_high);
                w_tick_d = (r_cnt == '0);
                // sync wins over the boundary, so a stopping channel keeps going one more period.
                if (i_sync) begin
                    w_cnt_d   = '0;
                    w_apply   = r_pend;
                    w_state_d = i_en ? StRun : StStopping;
                end else if (w_boundary) begin
                    w_cnt_d = '0;
                    w_apply = r_pend;
                    if (!i_en) begin
                        w_state_d = StIdle;
                        w_clk_d   = 1'b0;
                        w_tick_d  = 1'b0;
                    end else begin
                        w_state_d = StRun;
                    end
                end else begin
                    w_cnt_d   = r_cnt + DIV_W'(1);
                    w_state_d = i_en ? StRun : StStopping;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_apply) begin
            w_div_d  = r_sdiv;
            w_high_d = r_shigh;
            w_pend_d = 1'b0;
        end
        // A write is only accepted with nothing pending, so it never collides with w_apply.
        if (i_cfg_we) begin
            w_sdiv_d  = w_cfg_div_c;
            w_shigh_d = w_cfg_high_c;
            w_pend_d  = 1'b1;
        end
    end

    assign o_clk     = r_clk;
    assign o_tick    = r_tick;
    assign o_running = (r_state != StIdle);
    assign o_pending = r_pend;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel runtime-programmable clock divider: config decode, ready mux,
// reset release synchronizer and sync fan-out around NUM_CH channels.
module prog_clock_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DIV_W      = DIV_W_DEFAULT,
    parameter int unsigned DIV_RESET  = DIV_RESET_DEFAULT,
    parameter int unsigned HIGH_RESET = HIGH_RESET_DEFAULT,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_high,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);

    logic [1:0]        r_rst_sync;
    logic              w_rst;
    logic [NUM_CH-1:0] w_cfg_we;
    logic [NUM_CH-1:0] w_pend;

    // Assert immediately, release on a clock edge.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    // Out-of-range channel numbers stay ready so the write is accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !w_pend[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_cfg_we[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clk_div_channel #(
            .DIV_W      (DIV_W),
            .DIV_RESET  (DIV_RESET),
            .HIGH_RESET (HIGH_RESET)
        ) u_channel (
            .i_clk      (clk_100MHz),
            .i_rst      (w_rst),
            .i_cfg_we   (w_cfg_we[g]),
            .i_cfg_div  (cfg_div),
            .i_cfg_high (cfg_high),
            .i_en       (en[g]),
            .i_sync     (sync),
            .o_clk      (clk_out[g]),
            .o_tick     (tick[g]),
            .o_running  (running[g]),
            .o_pending  (w_pend[g])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: a behavioural model predicts every
// cycle's outputs, plus directed period/duty/stop/sync/reset checks.
module tb_prog_clock_divider;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned CH_W   = 2;

    typedef struct packed {
        logic [NUM_CH-1:0] ck;
        logic [NUM_CH-1:0] tk;
        logic [NUM_CH-1:0] rn;
    } exp_t;

    logic              clk_100MHz = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic [DIV_W-1:0]  cfg_high = '0;
    logic [NUM_CH-1:0] en = '0;
    logic              sync = 1'b0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] running;

    prog_clock_divider #(
        .NUM_CH     (NUM_CH),
        .DIV_W      (DIV_W),
        .DIV_RESET  (2),
        .HIGH_RESET (1)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_high   (cfg_high),
        .en         (en),
        .sync       (sync),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_cnt[NUM_CH];
    int unsigned m_div[NUM_CH];
    int unsigned m_high[NUM_CH];
    int unsigned m_sdiv[NUM_CH];
    int unsigned m_shigh[NUM_CH];
    bit          m_pend[NUM_CH];
    bit          m_run[NUM_CH];

    exp_t exp_q[$];
    int   obs_ticks[NUM_CH];
    int   obs_high[NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c]   = 0;
            m_div[c]   = 2;
            m_high[c]  = 1;
            m_sdiv[c]  = 2;
            m_shigh[c] = 1;
            m_pend[c]  = 1'b0;
            m_run[c]   = 1'b0;
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_edge(output exp_t e);
        bit          rdy;
        bit          acc;
        bit          apply;
        int unsigned d;
        int unsigned h;
        rdy = model_ready();
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc   = cfg_valid && rdy && (int'(cfg_ch) == c);
            apply = 1'b0;
            if (!m_run[c]) begin
                if (en[c]) begin
                    m_run[c] = 1'b1;
                    m_cnt[c] = 0;
                    apply    = m_pend[c];
                end
            end else begin
                e.ck[c] = (m_cnt[c] < m_high[c]);
                e.tk[c] = (m_cnt[c] == 0);
                if (sync) begin
                    m_cnt[c] = 0;
                    apply    = m_pend[c];
                end else if (m_cnt[c] + 1 == m_div[c]) begin
                    m_cnt[c] = 0;
                    apply    = m_pend[c];
                    if (!en[c]) m_run[c] = 1'b0;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (apply) begin
                m_div[c]  = m_sdiv[c];
                m_high[c] = m_shigh[c];
                m_pend[c] = 1'b0;
            end
            if (acc) begin
                d = (cfg_div < 2) ? 2 : int'(cfg_div);
                h = int'(cfg_high);
                if (h == 0) h = 1;
                if (h >= d) h = d - 1;
                m_sdiv[c]  = d;
                m_shigh[c] = h;
                m_pend[c]  = 1'b1;
            end
            e.rn[c] = m_run[c];
        end
    endtask

    task automatic clear_obs();
        for (int c = 0; c < NUM_CH; c++) begin
            obs_ticks[c] = 0;
            obs_high[c]  = 0;
        end
    endtask

    // One clock: predict, push, clock, then pop and compare.
    task automatic step();
        exp_t e;
        exp_t got;
        #1;
        check_eq("cfg_ready", 32'(cfg_ready), 32'(model_ready()));
        model_edge(e);
        exp_q.push_back(e);
        @(posedge clk_100MHz);
        #1;
        got = exp_q.pop_front();
        check_eq("clk_out", 32'(clk_out), 32'(got.ck));
        check_eq("tick", 32'(tick), 32'(got.tk));
        check_eq("running", 32'(running), 32'(got.rn));
        for (int c = 0; c < NUM_CH; c++) begin
            obs_ticks[c] += int'(tick[c]);
            obs_high[c]  += int'(clk_out[c]);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic write_cfg(input int ch, input int d, input int h);
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = DIV_W'(d);
        cfg_high  = DIV_W'(h);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_obs();
        rst = 1'b1;
        repeat (3) @(posedge clk_100MHz);
        #1;
        check_eq("rst_clk_out", 32'(clk_out), 32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        check_eq("rst_running", 32'(running), 32'h0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b0;
        steps(3);

        // Defaults: /2 on ch0 and ch1.
        en = 4'b0011;
        step();
        clear_obs();
        steps(8);
        check_eq("def_ch0_ticks", 32'(obs_ticks[0]), 32'd4);
        check_eq("def_ch1_ticks", 32'(obs_ticks[1]), 32'd4);
        check_eq("def_ch0_high", 32'(obs_high[0]), 32'd4);
        check_eq("def_ch2_ticks", 32'(obs_ticks[2]), 32'd0);

        // ch1 -> /10 with 5 high, applied at the next /2 boundary.
        write_cfg(1, 10, 5);
        check_eq("ch1_ready_pending", 32'(cfg_ready), 32'h0);
        step();
        check_eq("ch1_ready_applied", 32'(cfg_ready), 32'h1);
        clear_obs();
        steps(20);
        check_eq("ch1_div10_ticks", 32'(obs_ticks[1]), 32'd2);
        check_eq("ch1_div10_high", 32'(obs_high[1]), 32'd10);

        // Clamping on idle channels; pending applies at start.
        write_cfg(2, 1, 0);
        write_cfg(3, 8, 9);
        check_eq("ch3_ready_idle_pending", 32'(cfg_ready), 32'h0);
        en = 4'b1111;
        step();
        clear_obs();
        steps(16);
        check_eq("clamp_ch2_ticks", 32'(obs_ticks[2]), 32'd8);
        check_eq("clamp_ch2_high", 32'(obs_high[2]), 32'd8);
        check_eq("clamp_ch3_ticks", 32'(obs_ticks[3]), 32'd2);
        check_eq("clamp_ch3_high", 32'(obs_high[3]), 32'd14);

        // Stop ch0 at cnt=0 of a /10 period.
        write_cfg(0, 10, 5);
        for (int k = 0; k < 30; k++) begin
            if (!m_pend[0] && m_cnt[0] == 0) break;
            step();
        end
        if (m_pend[0] || m_cnt[0] != 0) check_eq("align_timeout", 32'h0, 32'h1);
        en = 4'b1110;
        clear_obs();
        steps(9);
        check_eq("stop_still_running", 32'(running[0]), 32'h1);
        step();
        check_eq("stop_parked_running", 32'(running[0]), 32'h0);
        check_eq("stop_parked_clk", 32'(clk_out[0]), 32'h0);
        check_eq("stop_ticks", 32'(obs_ticks[0]), 32'd1);
        check_eq("stop_high", 32'(obs_high[0]), 32'd5);

        // ch0 /4 and ch1 /6, then realign with sync.
        write_cfg(0, 4, 2);
        write_cfg(1, 6, 3);
        en = 4'b0011;
        for (int k = 0; k < 14; k++) begin
            if (!m_pend[1]) break;
            step();
        end
        if (m_pend[1]) check_eq("sync_setup_timeout", 32'h0, 32'h1);
        steps(3);
        sync = 1'b1;
        step();
        sync = 1'b0;
        step();
        check_eq("sync_tick", 32'(tick[1:0]), 32'h3);
        check_eq("sync_clk_out", 32'(clk_out[1:0]), 32'h3);
        steps(6);

        // Async reset mid-period with a pending write outstanding.
        write_cfg(1, 12, 3);
        step();
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_clk_out", 32'(clk_out), 32'h0);
        check_eq("async_rst_tick", 32'(tick), 32'h0);
        check_eq("async_rst_running", 32'(running), 32'h0);
        en = 4'b0000;
        @(posedge clk_100MHz);
        #1 rst = 1'b0;
        model_reset();
        exp_q.delete();
        steps(3);
        en = 4'b0011;
        step();
        clear_obs();
        steps(8);
        check_eq("post_rst_ch1_ticks", 32'(obs_ticks[1]), 32'd4);
        check_eq("post_rst_ch0_ticks", 32'(obs_ticks[0]), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
